// File: rtl/sys_burst_channel_engine.sv
// sys_burst_channel_engine: multi-channel burst framer.
// Beats arrive tagged with a channel. Each channel has its own enable,
// burst length and interrupt enable. Beats on an enabled channel are
// forwarded through a single output register, and out_last marks the final
// beat of each burst. Beats on a disabled channel are consumed and counted
// as drops. Sticky done/drop flags are reported through a status read port
// and are cleared when that port is read.
`timescale 1ns/1ps

module sys_burst_channel_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int MAX_BURST  = 256,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int LW        = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // configuration / status port
    input  logic                  cfg_we,
    input  logic                  cfg_re,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    // input stream
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] in_data,
    // output stream
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    // level interrupt
    output logic                  irq
);

    // per-channel configuration and state
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_irq_en;
    logic [LW-1:0]     r_len_m1 [NUM_CH];
    logic [LW-1:0]     r_count  [NUM_CH];
    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] r_drop;

    logic              w_accept;
    logic              w_fwd;
    logic              w_last;
    logic [31:0]       w_status;
    logic              w_unused_cfg;

    // The output register can take a new beat when it is empty, or when its
    // current beat leaves on this edge.
    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // The forward and last decisions use the configuration held before this
    // edge. A config write in the same cycle therefore cannot change how the
    // beat that is in flight is handled.
    assign w_fwd  = w_accept && r_en[in_ch];
    assign w_last = (r_count[in_ch] == r_len_m1[in_ch]);

    // A channel raises irq only while its done flag and its irq enable are both set.
    assign irq = |(r_done & r_irq_en);

    // Config bits this block does not implement.
    assign w_unused_cfg = ^{cfg_wdata[31:16+LW], cfg_wdata[15:2]};

    // Assemble the status word of the channel selected by cfg_ch, before this edge updates it.
    always_comb begin
        w_status             = '0;
        w_status[LW-1:0]     = r_count[cfg_ch];
        w_status[30]         = r_drop[cfg_ch];
        w_status[31]         = r_done[cfg_ch];
    end

    // Per-channel config, beat count and sticky flags.
    // NOTE: the config and count arrays are small flop arrays, not RAM, so the
    // async reset applies to every entry and channels come up disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= '0;
            r_irq_en <= '0;
            r_done   <= '0;
            r_drop   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_len_m1[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // A config write clears the count. If a beat on the same
                // channel is accepted in this cycle, the write still wins.
                if (cfg_we && cfg_ch == CH_W'(c)) begin
                    r_en[c]     <= cfg_wdata[0];
                    r_irq_en[c] <= cfg_wdata[1];
                    r_len_m1[c] <= cfg_wdata[16 +: LW];
                    r_count[c]  <= '0;
                end else if (w_fwd && in_ch == CH_W'(c)) begin
                    r_count[c]  <= w_last ? '0 : r_count[c] + LW'(1);
                end

                // Setting a flag takes priority over clearing it on read, so an event in the read cycle is not lost.
                if (w_fwd && w_last && in_ch == CH_W'(c))
                    r_done[c] <= 1'b1;
                else if (cfg_re && cfg_ch == CH_W'(c))
                    r_done[c] <= 1'b0;

                if (w_accept && !r_en[c] && in_ch == CH_W'(c))
                    r_drop[c] <= 1'b1;
                else if (cfg_re && cfg_ch == CH_W'(c))
                    r_drop[c] <= 1'b0;
            end
        end
    end

    // Status read: capture the status word as it was before this edge. The value holds until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg_rdata <= '0;
        else if (cfg_re)
            cfg_rdata <= w_status;
    end

    // Single output register stage. It loads when it is free to move and holds while stalled.
    // NOTE: non-blocking assignments here let every flop sample pre-edge values,
    // which is what makes in_ready and the load decision consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= w_fwd;
            if (w_fwd) begin
                out_data <= in_data;
                out_ch   <= in_ch;
                out_last <= w_last;
            end
        end
    end

endmodule

// File: tb/tb_sys_burst_channel_engine.sv
// Testbench for sys_burst_channel_engine.
// A driver pushes every forwarded beat into an expected-beat queue when the
// beat is accepted. A monitor pops the queue on each output transfer and
// compares the popped beat with the DUT output.
`timescale 1ns/1ps

module tb_sys_burst_channel_engine;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic          cfg_re = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ch = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_ch;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          irq;

    int    total = 0;
    int    bad   = 0;
    beat_t sb[$];

    sys_burst_channel_engine #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_BURST(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_ch(cfg_ch),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .out_last(out_last), .irq(irq)
    );

    always #5 clk = ~clk;

    // Monitor: inputs change just after the rising edge, so the values seen
    // on the falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        if (rst_n && out_valid && out_ready) begin
            got = '{ch: out_ch, data: out_data, last: out_last};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got ch=%0d data=%h last=%0b, expected none",
                         out_ch, out_data, out_last);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL out_beat: got ch=%0d data=%h last=%0b, expected ch=%0d data=%h last=%0b",
                             got.ch, got.data, got.last, exp.ch, exp.data, exp.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic [CW-1:0] ch, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [CW-1:0] ch, output logic [31:0] v);
        cfg_re = 1'b1; cfg_ch = ch;
        tick();
        cfg_re = 1'b0;
        v = cfg_rdata;
    endtask

    task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one beat and wait, up to a bounded number of cycles, for it to be
    // accepted. The expected output beat is queued only if it is forwarded.
    task automatic send(input logic [CW-1:0] ch, input logic [DW-1:0] d,
                        input bit fwd, input bit last);
        int n = 0;
        beat_t b;
        in_valid = 1'b1; in_ch = ch; in_data = d;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 within 20 cycles", in_ready);
        end else if (fwd) begin
            b = '{ch: ch, data: d, last: last};
            sb.push_back(b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        idle(2);
        expect32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        expect32("rst_irq",       {31'd0, irq},       32'd0);
        expect32("rst_cfg_rdata", cfg_rdata,          32'd0);
        expect32("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cfg_read(0, v);
        expect32("rst_status_ch0", v, 32'h0000_0000);
    endtask

    task automatic test_burst();
        logic [31:0] v;
        cfg_write(0, 32'h0003_0001);
        for (int i = 1; i <= 8; i++)
            send(0, 32'hA000_0000 + i, 1'b1, (i % 4) == 0);
        idle(2);
        cfg_read(0, v);
        expect32("burst_status_ch0", v, 32'h8000_0000);
    endtask

    task automatic test_drop();
        logic [31:0] v;
        send(2, 32'hDEAD_0002, 1'b0, 1'b0);
        idle(2);
        cfg_read(2, v);
        expect32("drop_status_1", v, 32'h4000_0000);
        cfg_read(2, v);
        expect32("drop_status_2", v, 32'h0000_0000);
    endtask

    task automatic test_irq();
        logic [31:0] v;
        cfg_write(1, 32'h0001_0003);
        send(1, 32'hB000_0001, 1'b1, 1'b0);
        expect32("irq_mid_burst", {31'd0, irq}, 32'd0);
        send(1, 32'hB000_0002, 1'b1, 1'b1);
        expect32("irq_after_burst", {31'd0, irq}, 32'd1);
        cfg_read(1, v);
        expect32("irq_status_ch1", v, 32'h8000_0000);
        expect32("irq_cleared", {31'd0, irq}, 32'd0);
    endtask

    task automatic test_backpressure();
        beat_t b;
        out_ready = 1'b0;
        send(0, 32'hC000_0001, 1'b1, 1'b0);
        in_valid = 1'b1; in_ch = 0; in_data = 32'hC000_0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect32("bp_in_ready", {31'd0, in_ready}, 32'd0);
            expect32("bp_out_valid", {31'd0, out_valid}, 32'd1);
            expect32("bp_out_data", out_data, 32'hC000_0001);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        expect32("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        b = '{ch: 2'd0, data: 32'hC000_0002, last: 1'b0};
        sb.push_back(b);
        tick();
        in_valid = 1'b0;
        idle(2);
    endtask

    task automatic test_interleave();
        logic [CW-1:0] seq [7];
        int cnt [2];
        int len_m1 [2];
        bit last;
        seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        len_m1[0] = 2; len_m1[1] = 1;
        cnt[0] = 0; cnt[1] = 0;
        cfg_write(0, 32'h0002_0001);
        cfg_write(1, 32'h0001_0001);
        for (int i = 0; i < 7; i++) begin
            last = (cnt[seq[i]] == len_m1[seq[i]]);
            cnt[seq[i]] = last ? 0 : cnt[seq[i]] + 1;
            send(seq[i], 32'hD000_0000 + i, 1'b1, last);
        end
        idle(2);
    endtask

    task automatic test_collision();
        logic [31:0] v;
        beat_t b;
        // ch0 has count 1 of a 3-beat burst. The write and the beat land on
        // the same edge: the beat is not last under the old length, and the
        // write forces the count to 0.
        cfg_we = 1'b1; cfg_ch = 0; cfg_wdata = 32'h0003_0001;
        in_valid = 1'b1; in_ch = 0; in_data = 32'hE000_0000;
        @(negedge clk);
        expect32("coll_in_ready", {31'd0, in_ready}, 32'd1);
        b = '{ch: 2'd0, data: 32'hE000_0000, last: 1'b0};
        sb.push_back(b);
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        cfg_read(0, v);
        expect32("coll_status_ch0", v, 32'h8000_0000);
        for (int i = 1; i <= 4; i++)
            send(0, 32'hE000_0000 + i, 1'b1, i == 4);
        idle(2);
    endtask

    task automatic test_len1_sticky();
        logic [31:0] v;
        beat_t b;
        cfg_write(2, 32'h0000_0001);
        send(2, 32'hF000_0001, 1'b1, 1'b1);
        // A read and a new done event on the same edge: the read returns the
        // pre-edge status, and the done flag stays set.
        cfg_re = 1'b1; cfg_ch = 2;
        in_valid = 1'b1; in_ch = 2; in_data = 32'hF000_0002;
        @(negedge clk);
        b = '{ch: 2'd2, data: 32'hF000_0002, last: 1'b1};
        sb.push_back(b);
        tick();
        cfg_re = 1'b0; in_valid = 1'b0;
        expect32("len1_read_pre", cfg_rdata, 32'h8000_0000);
        send(2, 32'hF000_0003, 1'b1, 1'b1);
        idle(2);
        cfg_read(2, v);
        expect32("len1_read_kept", v, 32'h8000_0000);
        cfg_read(2, v);
        expect32("len1_read_cleared", v, 32'h0000_0000);
        expect32("len1_irq", {31'd0, irq}, 32'd0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        cfg_read(0, v);
        expect32("pre_rst_status_ch0", v, 32'h8000_0000);
        cfg_write(0, 32'h0003_0001);
        send(0, 32'h1000_0001, 1'b1, 1'b0);
        send(0, 32'h1000_0002, 1'b1, 1'b0);
        // The second beat is still in the output register when reset hits.
        rst_n = 1'b0;
        #1;
        sb.delete();
        expect32("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        expect32("mid_rst_out_data",  out_data,           32'd0);
        expect32("mid_rst_out_ch",    {30'd0, out_ch},    32'd0);
        expect32("mid_rst_out_last",  {31'd0, out_last},  32'd0);
        expect32("mid_rst_irq",       {31'd0, irq},       32'd0);
        expect32("mid_rst_cfg_rdata", cfg_rdata,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cfg_read(0, v);
        expect32("post_rst_status_ch0", v, 32'h0000_0000);
        cfg_write(0, 32'h0003_0001);
        for (int i = 1; i <= 4; i++)
            send(0, 32'h2000_0000 + i, 1'b1, i == 4);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_drop();
        test_irq();
        test_backpressure();
        test_interleave();
        test_collision();
        test_len1_sticky();
        test_reset_mid();
        expect32("queue_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
        $fatal(1);
    end

endmodule

// File: doc/sys_burst_channel_engine.md
SYS_BURST_CHANNEL_ENGINE -- requirements
Module: sys_burst_channel_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream data width.
REQ-002 SHALL have parameter NUM_CH, default 4: channel count, power of two, 2..16; CH_W = clog2(NUM_CH).
REQ-003 SHALL have parameter MAX_BURST, default 256: maximum beats per burst, power of two; LW = clog2(MAX_BURST).
REQ-004 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: cfg_we  input  1  config register write strobe.
REQ-007 SHALL have port: cfg_re  input  1  status register read strobe.
REQ-008 SHALL have port: cfg_ch  input  CH_W  channel selected by cfg_we/cfg_re.
REQ-009 SHALL have port: cfg_wdata  input  32  config write data.
REQ-010 SHALL have port: cfg_rdata  output  32  status read data.
REQ-011 SHALL have ports: in_valid input 1, in_ready output 1, in_ch input CH_W, in_data input DATA_WIDTH: input stream.
REQ-012 SHALL have ports: out_valid output 1, out_ready input 1, out_ch output CH_W, out_data output DATA_WIDTH, out_last output 1: output stream.
REQ-013 SHALL have port: irq  output  1  level interrupt.

Function
REQ-014 Per-channel config SHALL be: bit0 enable, bit1 irq_en, bits[16+LW-1:16] burst_len_m1 (burst length minus one).
REQ-015 cfg_we SHALL write config of channel cfg_ch and clear that channel's beat count to 0.
REQ-016 Per-channel status SHALL be: bits[LW-1:0] beat count, bit30 drop sticky, bit31 done sticky, others 0.
REQ-017 cfg_re SHALL load cfg_rdata with status of cfg_ch on next edge (1-cycle latency) and clear that channel's sticky bits in the same edge; cfg_rdata holds until next cfg_re.
REQ-018 A sticky set and a read-clear of the same bit in the same cycle SHALL leave the bit set; cfg_rdata shows pre-update value.
REQ-019 Output SHALL be a single register stage; in_ready = !out_valid || out_ready, combinational.
REQ-020 Input beat accepted (in_valid && in_ready) on enabled channel SHALL load out_data/out_ch next cycle with out_valid=1.
REQ-021 out_last SHALL be 1 when accepted beat's channel beat count equals burst_len_m1; count then wraps to 0 and done sticky sets.
REQ-022 Otherwise accepted beat SHALL increment channel beat count by 1.
REQ-023 Accepted beat on disabled channel SHALL be consumed, not forwarded, set drop sticky, leave count unchanged.
REQ-024 out_valid, out_data, out_ch, out_last SHALL hold while out_valid && !out_ready.
REQ-025 Simultaneous cfg_we and accepted beat on same channel: beat SHALL use old config for forward/last decision; count result SHALL be 0 (write wins).
REQ-026 burst_len_m1 = 0 SHALL give out_last on every beat.
REQ-027 irq SHALL equal OR over channels of (done sticky AND irq_en), registered-state derived, no extra latency.
REQ-028 Channels SHALL be independent; beats of different channels MAY interleave, each counted separately.

Reset
REQ-029 rst_n low SHALL asynchronously clear all config, counts, sticky bits, cfg_rdata, out_valid, out_data, out_ch, out_last, irq to 0.
REQ-030 After reset all channels SHALL be disabled; in_ready SHALL be 1 (beats dropped with drop sticky).
REQ-031 Reset mid-burst SHALL discard partial count and any pending output beat.

Verification
REQ-032 Ch0 cfg 0x0003_0001 (len 4), 8 beats, out_ready=1 -> out_last on beats 4 and 8, ch0 done sticky=1, count=0.
REQ-033 Ch2 disabled, 1 beat to ch2 -> no out_valid, cfg_re ch2 -> cfg_rdata=0x4000_0000; second cfg_re -> 0x0000_0000.
REQ-034 Ch1 len 2 irq_en=1, 2 beats -> irq=1 after second beat; cfg_re ch1 -> irq=0 next cycle.
REQ-035 out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, output stable; out_ready=1 -> transfer, next beat accepted same cycle.
REQ-036 Ch0/ch1 interleaved beats, ch0 len 3, ch1 len 2 -> out_last per channel independently at correct beats.
REQ-037 rst_n pulse after 2 of 4 beats on ch0 -> all outputs 0; after re-config full 4-beat burst gives out_last on 4th.
